// File: rtl/cache_read_arbiter_pkg.sv
// Shared request type for the cache read arbiter.
// The request layout is fixed here so that every requester and the read interface agree on it.
package cache_read_arbiter_pkg;

   localparam int ID_LEN    = 2;
   localparam int LEN_BITS  = 8;
   localparam int ADDR_BITS = 10;

   typedef struct packed {
      logic [31:0]          mmioData;
      logic                 mmio;
      logic [LEN_BITS-1:0]  len;
      logic [ADDR_BITS-1:0] addr;
      logic [ID_LEN-1:0]    id;
   } CacheReadReq;

endpackage

// File: rtl/cache_read_arbiter_rr_picker.sv
// Round-robin picker: selects the lowest set mask bit at or above rr_ptr, wrapping to 0.
// Outputs the one-hot grant and the binary winner index.
module rr_picker #(
   parameter int NUM_REQ = 3,
   localparam int PTR_W = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_mask,
   input  logic [PTR_W-1:0]   rr_ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [PTR_W-1:0]   winner
);

   logic [NUM_REQ-1:0] upper_mask;
   logic [NUM_REQ-1:0] sel_mask;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_upper
      assign upper_mask[gi] = req_mask[gi] && (PTR_W'(gi) >= rr_ptr);
   end

   // Requests at or above the pointer win first; otherwise fall back to the wrapped search.
   assign sel_mask = (|upper_mask) ? upper_mask : req_mask;

   always_comb begin
      winner = '0;
      grant  = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (sel_mask[i]) begin
            winner = PTR_W'(i);
         end
      end
      grant[winner] = |sel_mask;
   end

endmodule

// File: rtl/cache_read_arbiter.sv
// Round-robin arbiter feeding a one-entry request slot, with an outstanding-transfer limit.
// Optional MMIO priority: define CACHE_READ_ARB_MMIO_PRIO_EN.
module cache_read_arbiter
   import cache_read_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int MAX_OUT = 2,
   localparam int PTR_W = $clog2(NUM_REQ),
   localparam int OUT_W = $clog2(MAX_OUT + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_REQ-1:0]  IN_reqValid,
   output logic [NUM_REQ-1:0]  OUT_reqReady,
   input  CacheReadReq         IN_req [NUM_REQ],
   output logic                OUT_valid,
   output CacheReadReq         OUT_req,
   input  logic                IN_ready,
   input  logic                IN_strValid,
   input  logic                IN_strReady,
   input  logic                IN_strLast,
   output logic [OUT_W-1:0]    OUT_outstanding
);

   logic               out_valid_reg, out_valid_next;
   CacheReadReq        out_req_reg, out_req_next;
   logic [PTR_W-1:0]   rr_ptr_reg, rr_ptr_next;
   logic [OUT_W-1:0]   outstanding_reg, outstanding_next;

   logic               slot_free;
   logic               completion;
   logic               cpl_counted;
   logic               grant_en;
   logic [NUM_REQ-1:0] pick_mask;
   logic [NUM_REQ-1:0] pick_grant;
   logic [PTR_W-1:0]   winner;

   assign slot_free   = !out_valid_reg || IN_ready;
   assign completion  = IN_strValid && IN_strReady && IN_strLast;
   assign cpl_counted = completion && (outstanding_reg != '0);

   // The limit uses the registered count only, so a same-cycle completion never frees a slot early.
   assign grant_en = !rst && slot_free && (|IN_reqValid)
                     && (outstanding_reg < OUT_W'(MAX_OUT));

`ifdef CACHE_READ_ARB_MMIO_PRIO_EN
   logic [NUM_REQ-1:0] mmio_valid;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mmio
      assign mmio_valid[gi] = IN_reqValid[gi] && IN_req[gi].mmio;
   end

   assign pick_mask = (|mmio_valid) ? mmio_valid : IN_reqValid;
`else
   assign pick_mask = IN_reqValid;
`endif

   rr_picker #(
      .NUM_REQ (NUM_REQ)
   ) u_picker (
      .req_mask (pick_mask),
      .rr_ptr   (rr_ptr_reg),
      .grant    (pick_grant),
      .winner   (winner)
   );

   assign OUT_reqReady    = grant_en ? pick_grant : '0;
   assign OUT_valid       = out_valid_reg;
   assign OUT_req         = out_req_reg;
   assign OUT_outstanding = outstanding_reg;

   always_comb begin
      out_valid_next   = out_valid_reg;
      out_req_next     = out_req_reg;
      rr_ptr_next      = rr_ptr_reg;
      outstanding_next = outstanding_reg;

      if (grant_en) begin
         out_valid_next = 1'b1;
         out_req_next   = IN_req[winner];
         rr_ptr_next    = (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
      end else if (IN_ready) begin
         out_valid_next = 1'b0;
      end

      if (grant_en && !cpl_counted) begin
         outstanding_next = outstanding_reg + 1'b1;
      end else if (!grant_en && cpl_counted) begin
         outstanding_next = outstanding_reg - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_reg   <= 1'b0;
         out_req_reg     <= '0;
         rr_ptr_reg      <= '0;
         outstanding_reg <= '0;
      end else begin
         out_valid_reg   <= out_valid_next;
         out_req_reg     <= out_req_next;
         rr_ptr_reg      <= rr_ptr_next;
         outstanding_reg <= outstanding_next;
      end
   end

   // A last beat with nothing outstanding is dropped; flag it so the upstream bug is visible.
   a_no_spurious_completion: assert property (
      @(posedge clk) disable iff (rst) !(completion && outstanding_reg == '0))
      else $warning("cache_read_arbiter: completion with no outstanding transfer ignored");

endmodule

// File: tb/tb_cache_read_arbiter.sv
// Self-checking bench for cache_read_arbiter: directed vector table, hand-written corner
// sequences and a randomized run against a behavioural model (honours CACHE_READ_ARB_MMIO_PRIO_EN).
module tb_cache_read_arbiter;
   import cache_read_arbiter_pkg::*;

   localparam int N    = 3;
   localparam int MAXO = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [N-1:0]  req_valid;
   logic [N-1:0]  req_ready;
   CacheReadReq   req [N];
   logic          out_valid;
   CacheReadReq   out_req;
   logic          in_ready;
   logic          str_valid;
   logic          str_ready;
   logic          str_last;
   logic [1:0]    outstanding;

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   cache_read_arbiter #(
      .NUM_REQ (N),
      .MAX_OUT (MAXO)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .IN_reqValid     (req_valid),
      .OUT_reqReady    (req_ready),
      .IN_req          (req),
      .OUT_valid       (out_valid),
      .OUT_req         (out_req),
      .IN_ready        (in_ready),
      .IN_strValid     (str_valid),
      .IN_strReady     (str_ready),
      .IN_strLast      (str_last),
      .OUT_outstanding (outstanding)
   );

   function automatic logic [63:0] req_bits(input CacheReadReq q);
      logic [63:0] r;
      r = '0;
      r[$bits(CacheReadReq)-1:0] = q;
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   typedef struct {
      logic [N-1:0] valid;
      logic         ready;
      logic         cpl;
      logic [N-1:0] exp_grant;
      logic         exp_valid;
      logic [9:0]   exp_addr;
      int           exp_out;
   } vec_t;

   vec_t vecs [24];

   function automatic vec_t mk(input logic [N-1:0] v, input logic r, input logic c,
                               input logic [N-1:0] g, input logic ov, input logic [9:0] a,
                               input int o);
      vec_t x;
      x.valid = v; x.ready = r; x.cpl = c;
      x.exp_grant = g; x.exp_valid = ov; x.exp_addr = a; x.exp_out = o;
      return x;
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Behavioural model state for the randomized run
   logic        m_valid;
   CacheReadReq m_req;
   int          m_out;
   int          m_rr;

   initial begin
      req_valid = '0;
      in_ready  = 1'b0;
      str_valid = 1'b0;
      str_ready = 1'b0;
      str_last  = 1'b0;
      for (int i = 0; i < N; i++) begin
         req[i] = '{mmioData: 32'hA000_0000 + 32'(i), mmio: 1'b0, len: 8'(i + 1),
                    addr: 10'h40 + 10'(i), id: 2'(i)};
      end

      //                valid   rdy  cpl  grant   ov    addr    out
      vecs[0]  = mk(3'b001, 1'b1, 1'b0, 3'b001, 1'b0, 10'h000, 0);
      vecs[1]  = mk(3'b000, 1'b1, 1'b0, 3'b000, 1'b1, 10'h040, 1);
      vecs[2]  = mk(3'b111, 1'b1, 1'b0, 3'b010, 1'b0, 10'h040, 1);
      vecs[3]  = mk(3'b111, 1'b1, 1'b0, 3'b000, 1'b1, 10'h041, 2);
      vecs[4]  = mk(3'b111, 1'b1, 1'b1, 3'b000, 1'b0, 10'h041, 2);
      vecs[5]  = mk(3'b111, 1'b1, 1'b0, 3'b100, 1'b0, 10'h041, 1);
      vecs[6]  = mk(3'b111, 1'b0, 1'b1, 3'b000, 1'b1, 10'h042, 2);
      vecs[7]  = mk(3'b111, 1'b0, 1'b0, 3'b000, 1'b1, 10'h042, 1);
      vecs[8]  = mk(3'b111, 1'b0, 1'b0, 3'b000, 1'b1, 10'h042, 1);
      vecs[9]  = mk(3'b111, 1'b0, 1'b0, 3'b000, 1'b1, 10'h042, 1);
      vecs[10] = mk(3'b111, 1'b1, 1'b0, 3'b001, 1'b1, 10'h042, 1);
      vecs[11] = mk(3'b000, 1'b1, 1'b1, 3'b000, 1'b1, 10'h040, 2);
      vecs[12] = mk(3'b010, 1'b1, 1'b1, 3'b010, 1'b0, 10'h040, 1);
      vecs[13] = mk(3'b000, 1'b1, 1'b1, 3'b000, 1'b1, 10'h041, 1);
      vecs[14] = mk(3'b000, 1'b1, 1'b1, 3'b000, 1'b0, 10'h041, 0);
      vecs[15] = mk(3'b000, 1'b1, 1'b0, 3'b000, 1'b0, 10'h041, 0);
      vecs[16] = mk(3'b111, 1'b1, 1'b0, 3'b100, 1'b0, 10'h041, 0);
      vecs[17] = mk(3'b111, 1'b1, 1'b1, 3'b001, 1'b1, 10'h042, 1);
      vecs[18] = mk(3'b111, 1'b1, 1'b1, 3'b010, 1'b1, 10'h040, 1);
      vecs[19] = mk(3'b111, 1'b1, 1'b1, 3'b100, 1'b1, 10'h041, 1);
      vecs[20] = mk(3'b111, 1'b1, 1'b1, 3'b001, 1'b1, 10'h042, 1);
      vecs[21] = mk(3'b111, 1'b1, 1'b1, 3'b010, 1'b1, 10'h040, 1);
      vecs[22] = mk(3'b000, 1'b1, 1'b1, 3'b000, 1'b1, 10'h041, 1);
      vecs[23] = mk(3'b000, 1'b1, 1'b0, 3'b000, 1'b0, 10'h041, 0);

      // Reset state, with requests pending so the grant must stay masked
      req_valid = 3'b111;
      @(negedge clk);
      check("reset_grant", 64'(req_ready), 64'(3'b000));
      check("reset_valid", 64'(out_valid), 64'(1'b0));
      check("reset_req", req_bits(out_req), 64'h0);
      check("reset_outstanding", 64'(outstanding), 64'(0));
      @(posedge clk);
      #1 rst = 1'b0;

      // Directed table
      for (int r = 0; r < 24; r++) begin
         req_valid = vecs[r].valid;
         in_ready  = vecs[r].ready;
         str_valid = vecs[r].cpl;
         str_ready = 1'b1;
         str_last  = 1'b1;
         @(negedge clk);
         $display("row %0d: valid=%b grant=%b out_valid=%b addr=0x%0h outstanding=%0d",
                  r, req_valid, req_ready, out_valid, out_req.addr, outstanding);
         check($sformatf("row%0d_grant", r), 64'(req_ready), 64'(vecs[r].exp_grant));
         check($sformatf("row%0d_valid", r), 64'(out_valid), 64'(vecs[r].exp_valid));
         check($sformatf("row%0d_addr", r), 64'(out_req.addr), 64'(vecs[r].exp_addr));
         check($sformatf("row%0d_outstanding", r), 64'(outstanding), 64'(vecs[r].exp_out));
         @(posedge clk);
         #1;
      end

      // Reset in the middle of a transfer: slot full, count 1, then asynchronous reset
      str_valid = 1'b0;
      req_valid = 3'b001;
      in_ready  = 1'b0;
      @(negedge clk);
      check("midrst_grant", 64'(req_ready), 64'(3'b001));
      @(posedge clk);
      #1 req_valid = 3'b111;
      @(negedge clk);
      check("midrst_pre_valid", 64'(out_valid), 64'(1'b1));
      check("midrst_pre_outstanding", 64'(outstanding), 64'(1));
      #1 rst = 1'b1;
      #1;
      check("midrst_valid", 64'(out_valid), 64'(1'b0));
      check("midrst_req", req_bits(out_req), 64'h0);
      check("midrst_outstanding", 64'(outstanding), 64'(0));
      check("midrst_grant_masked", 64'(req_ready), 64'(3'b000));
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;

      // MMIO priority: req0 cached, req2 mmio, pointer at 0
      req[2].mmio = 1'b1;
      req_valid   = 3'b101;
      in_ready    = 1'b1;
      @(negedge clk);
`ifdef CACHE_READ_ARB_MMIO_PRIO_EN
      check("mmio_first_grant", 64'(req_ready), 64'(3'b100));
`else
      check("mmio_first_grant", 64'(req_ready), 64'(3'b001));
`endif
      @(posedge clk);
      #1 req_valid = 3'b000;
      @(negedge clk);
`ifdef CACHE_READ_ARB_MMIO_PRIO_EN
      check("mmio_first_addr", 64'(out_req.addr), 64'(10'h042));
`else
      check("mmio_first_addr", 64'(out_req.addr), 64'(10'h040));
`endif
      check("mmio_first_outstanding", 64'(outstanding), 64'(1));
      $display("mmio test: granted addr=0x%0h mmio=%b", out_req.addr, out_req.mmio);

      // Randomized run against the behavioural model
      do_reset();
      m_valid = 1'b0;
      m_req   = '0;
      m_out   = 0;
      m_rr    = 0;
      begin
         logic [N-1:0] hold;
         hold = '0;
         for (int cyc = 0; cyc < 400; cyc++) begin
            int           winner;
            int           old_out;
            logic [N-1:0] cand;
            logic [N-1:0] exp_grant;
            logic         cpl;

            for (int i = 0; i < N; i++) begin
               if (!hold[i]) begin
                  req_valid[i]    = 1'($urandom_range(0, 1));
                  req[i].mmioData = $urandom;
                  req[i].mmio     = ($urandom_range(0, 3) == 0);
                  req[i].len      = 8'($urandom);
                  req[i].addr     = 10'($urandom);
                  req[i].id       = 2'($urandom);
               end
            end
            in_ready  = ($urandom_range(0, 3) != 0);
            str_valid = 1'($urandom_range(0, 1));
            str_ready = 1'($urandom_range(0, 1));
            str_last  = (m_out > 0) ? 1'($urandom_range(0, 1)) : 1'b0;

            @(negedge clk);
            cand = req_valid;
`ifdef CACHE_READ_ARB_MMIO_PRIO_EN
            begin
               logic [N-1:0] mm;
               for (int i = 0; i < N; i++) mm[i] = req_valid[i] && req[i].mmio;
               if (mm != '0) cand = mm;
            end
`endif
            winner = -1;
            if ((!m_valid || in_ready) && req_valid != '0 && m_out < MAXO) begin
               for (int k = 0; k < N; k++) begin
                  int idx;
                  idx = (m_rr + k) % N;
                  if (winner < 0 && cand[idx]) winner = idx;
               end
            end
            exp_grant = '0;
            if (winner >= 0) exp_grant[winner] = 1'b1;

            check("rnd_grant", 64'(req_ready), 64'(exp_grant));
            check("rnd_valid", 64'(out_valid), 64'(m_valid));
            if (m_valid) check("rnd_req", req_bits(out_req), req_bits(m_req));
            check("rnd_outstanding", 64'(outstanding), 64'(m_out));
            if (winner >= 0) begin
               $display("cycle %0d: grant req%0d addr=0x%0h mmio=%b outstanding=%0d",
                        cyc, winner, req[winner].addr, req[winner].mmio, m_out);
            end

            cpl     = str_valid && str_ready && str_last;
            old_out = m_out;
            m_out   = old_out + ((winner >= 0) ? 1 : 0) - ((cpl && old_out > 0) ? 1 : 0);
            if (winner >= 0) begin
               m_valid = 1'b1;
               m_req   = req[winner];
               m_rr    = (winner + 1) % N;
            end else if (in_ready) begin
               m_valid = 1'b0;
            end
            hold = req_valid & ~exp_grant;

            @(posedge clk);
            #1;
         end
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
